// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: format defaults, divider state encoding and
// saturation constants (also used by the ALU).
package fixed_point_pkg;

   localparam int Q_DEFAULT = 12;
   localparam int N_DEFAULT = 32;
   localparam int SAT_W     = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Largest positive value of an n-bit two's complement word (n <= SAT_W).
   function automatic logic [SAT_W-1:0] sat_pos(input int n);
      return (SAT_W'(1) << (n - 1)) - SAT_W'(1);
   endfunction

   // Most negative value of an n-bit word; the low n bits are the pattern.
   function automatic logic [SAT_W-1:0] sat_neg(input int n);
      return SAT_W'(1) << (n - 1);
   endfunction

endpackage

// File: rtl/fixed_point_negate.sv
// Conditional two's-complement negation; used for operand magnitudes and to
// apply the result sign.
module fixed_point_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         neg,
   output logic [W-1:0] result
);

   assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: out = trunc((a * 2^Q) / b), one
// restoring step per cycle. Define FIXED_POINT_DIVIDER_SATURATE_EN to clamp
// overflowing results instead of returning the low N quotient bits.
module fixed_point_divider
   import fixed_point_pkg::*;
#(
   parameter int Q = Q_DEFAULT,
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         overflow,
   output logic         div_by_zero
);

   localparam int W  = N + Q;
   localparam int CW = $clog2(W + 1);
   localparam logic [SAT_W-1:0] POS_LIMIT_W = sat_pos(N);
   localparam logic [W-1:0]     POS_LIMIT   = POS_LIMIT_W[W-1:0];
   localparam logic [W-1:0]     NEG_LIMIT   = POS_LIMIT + W'(1);
`ifdef FIXED_POINT_DIVIDER_SATURATE_EN
   localparam logic [SAT_W-1:0] SAT_NEG_W = sat_neg(N);
   localparam logic [N-1:0]     SAT_POS   = POS_LIMIT_W[N-1:0];
   localparam logic [N-1:0]     SAT_NEG   = SAT_NEG_W[N-1:0];
`endif

   div_state_t      state_reg, state_next;
   logic [CW-1:0]   count_reg;
   logic            sign_reg;
   logic [N-1:0]    mag_b_reg;
   logic [N-1:0]    rem_reg;
   logic [W-1:0]    work_reg;
   logic [N-1:0]    out_reg;
   logic            ovf_reg;
   logic            dbz_reg;

   logic [1:0][N-1:0] op_raw;
   logic [1:0][N-1:0] op_mag;
   logic [N:0]        rem_shift;
   logic              step_ge;
   logic [N-1:0]      rem_sub;
   logic [N-1:0]      signed_low;
   logic              dbz_next;
   logic              ovf_next;
   logic [N-1:0]      result_next;

   assign op_raw = {b, a};

   // Index 0 yields |a|, index 1 yields |b|; the most negative input maps to 2^(N-1).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_mag
         fixed_point_negate #(.W(N)) u_neg_op (
            .value  (op_raw[gi]),
            .neg    (op_raw[gi][N-1]),
            .result (op_mag[gi])
         );
      end
   endgenerate

   // Negation commutes with truncation, so only the low N quotient bits are signed.
   fixed_point_negate #(.W(N)) u_neg_q (
      .value  (work_reg[N-1:0]),
      .neg    (sign_reg),
      .result (signed_low)
   );

   // work_reg shifts dividend bits out of the top while quotient bits enter below.
   assign rem_shift = {rem_reg, work_reg[W-1]};
   assign step_ge   = rem_shift >= {1'b0, mag_b_reg};
   assign rem_sub   = rem_shift[N-1:0] - mag_b_reg;

   assign dbz_next = (mag_b_reg == '0);
   assign ovf_next = dbz_next |
                     (sign_reg ? (work_reg > NEG_LIMIT) : (work_reg > POS_LIMIT));

   always_comb begin
      result_next = signed_low;
`ifdef FIXED_POINT_DIVIDER_SATURATE_EN
      if (ovf_next) begin
         result_next = sign_reg ? SAT_NEG : SAT_POS;
      end
`endif
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (in_valid) state_next = CALC;
         // One cycle past the last step is spent in CALC so FIX sees a settled quotient.
         CALC: if (count_reg == CW'(W)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
         sign_reg  <= 1'b0;
         mag_b_reg <= '0;
         rem_reg   <= '0;
         work_reg  <= '0;
         out_reg   <= '0;
         ovf_reg   <= 1'b0;
         dbz_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  sign_reg  <= a[N-1] ^ b[N-1];
                  mag_b_reg <= op_mag[1];
                  rem_reg   <= '0;
                  work_reg  <= {op_mag[0], {Q{1'b0}}};
                  count_reg <= '0;
               end
            end
            CALC: begin
               if (count_reg != CW'(W)) begin
                  rem_reg   <= step_ge ? rem_sub : rem_shift[N-1:0];
                  work_reg  <= {work_reg[W-2:0], step_ge};
                  count_reg <= count_reg + CW'(1);
               end
            end
            FIX: begin
               out_reg <= result_next;
               ovf_reg <= ovf_next;
               dbz_reg <= dbz_next;
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready    = (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign out         = out_reg;
   assign overflow    = ovf_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed table, handshake and
// reset sequences, and random operands against an arithmetic reference model.
module tb_fixed_point_divider;

   localparam int N   = 32;
   localparam int Q   = 12;
   localparam int LAT = N + Q + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out;
   logic         out_valid;
   logic         out_ready;
   logic         overflow;
   logic         div_by_zero;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fixed_point_divider #(.Q(Q), .N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .b           (b),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out         (out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

`ifdef FIXED_POINT_DIVIDER_SATURATE_EN
   localparam logic [31:0] DIV0_POS_OUT = 32'h7FFF_FFFF;
   localparam logic [31:0] DIV0_NEG_OUT = 32'h8000_0000;
   localparam logic [31:0] BIG_OUT      = 32'h7FFF_FFFF;
   localparam logic [31:0] PLUS2_31_OUT = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] DIV0_POS_OUT = 32'hFFFF_FFFF;
   localparam logic [31:0] DIV0_NEG_OUT = 32'h0000_0001;
   localparam logic [31:0] BIG_OUT      = 32'hFF00_0000;
   localparam logic [31:0] PLUS2_31_OUT = 32'h8000_0000;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_out;
      logic        exp_ovf;
      logic        exp_dbz;
      string       name;
   } vec_t;

   vec_t vecs[11];

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: exact integer quotient of a*2^Q by b, truncated toward zero.
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                 output logic [31:0] eo, output logic eovf, output logic edbz);
      longint sa, sb, q;
      sa = $signed(ma);
      sb = $signed(mb);
      if (sb == 0) begin
         edbz = 1'b1;
         eovf = 1'b1;
         eo   = (sa < 0) ? DIV0_NEG_OUT : DIV0_POS_OUT;
      end else begin
         q    = (sa * 4096) / sb;
         edbz = 1'b0;
         eovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
         eo   = 32'(q);
`ifdef FIXED_POINT_DIVIDER_SATURATE_EN
         if (eovf) eo = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      end
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 200);
      if (!out_valid) begin
         tests++;
         fails++;
         $display("FAIL timeout: out_valid low after %0d cycles, expected within %0d", lat, LAT);
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv,
                        output logic [31:0] r_out, output logic r_ovf, output logic r_dbz,
                        output int lat);
      @(negedge clk);
      a        = ta;
      b        = tbv;
      in_valid = 1'b1;
      check32("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(lat);
      r_out = out;
      r_ovf = overflow;
      r_dbz = div_by_zero;
      release_result();
   endtask

   initial begin
      logic [31:0] r_out, e_out, held, ra, rb;
      logic        r_ovf, r_dbz, e_ovf, e_dbz;
      int          lat;

      vecs[0]  = '{32'h0000_6000, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b0, "six_by_two"};
      vecs[1]  = '{32'hFFFF_8800, 32'h0000_2000, 32'hFFFF_C400, 1'b0, 1'b0, "neg_7p5_by_two"};
      vecs[2]  = '{32'h0000_1000, 32'h0000_3000, 32'h0000_0555, 1'b0, 1'b0, "one_third_trunc"};
      vecs[3]  = '{32'h0000_1000, 32'h0000_0000, DIV0_POS_OUT,  1'b1, 1'b1, "div0_pos"};
      vecs[4]  = '{32'hFFFF_F000, 32'h0000_0000, DIV0_NEG_OUT,  1'b1, 1'b1, "div0_neg"};
      vecs[5]  = '{32'h0000_0000, 32'h0000_0000, DIV0_POS_OUT,  1'b1, 1'b1, "div0_zero"};
      vecs[6]  = '{32'h7FFF_F000, 32'h0000_0001, BIG_OUT,       1'b1, 1'b0, "big_overflow"};
      vecs[7]  = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, "zero_dividend"};
      vecs[8]  = '{32'hFFFF_F000, 32'hFFFF_F000, 32'h0000_1000, 1'b0, 1'b0, "neg_by_neg"};
      vecs[9]  = '{32'h8000_0000, 32'h0000_1000, 32'h8000_0000, 1'b0, 1'b0, "min_by_one"};
      vecs[10] = '{32'h8000_0000, 32'hFFFF_F000, PLUS2_31_OUT,  1'b1, 1'b0, "min_by_neg_one"};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check32("rst_in_ready", 32'(in_ready), 32'd1);
      check32("rst_out_valid", 32'(out_valid), 32'd0);
      check32("rst_out", out, 32'd0);
      check32("rst_overflow", 32'(overflow), 32'd0);
      check32("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].a, vecs[i].b, r_out, r_ovf, r_dbz, lat);
         $display("[TB] %s a=%h b=%h out=%h ovf=%0d dbz=%0d lat=%0d",
                  vecs[i].name, vecs[i].a, vecs[i].b, r_out, r_ovf, r_dbz, lat);
         check32({vecs[i].name, "_out"}, r_out, vecs[i].exp_out);
         check32({vecs[i].name, "_ovf"}, 32'(r_ovf), 32'(vecs[i].exp_ovf));
         check32({vecs[i].name, "_dbz"}, 32'(r_dbz), 32'(vecs[i].exp_dbz));
         check_int({vecs[i].name, "_latency"}, lat, LAT);
      end

      // Result held in DONE while out_ready stays low and in_valid is ignored.
      @(negedge clk);
      a = 32'h0000_6000;
      b = 32'h0000_2000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(lat);
      check_int("hold_latency", lat, LAT);
      check32("hold_first_out", out, 32'h0000_3000);
      held = out;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = 32'h0000_4000;
         b = 32'h0000_2000;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         check32("hold_out", out, held);
         check32("hold_out_valid", 32'(out_valid), 32'd1);
         check32("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check32("release_out_valid", 32'(out_valid), 32'd0);
      check32("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check32("next_accepted", 32'(in_ready), 32'd0);
      wait_done(lat);
      $display("[TB] hold_then_next a=00004000 b=00002000 out=%h lat=%0d", out, lat);
      check_int("next_latency", lat, LAT);
      check32("next_out", out, 32'h0000_2000);
      release_result();

      // Reset 20 cycles into CALC, with in_valid and out_ready also high.
      @(negedge clk);
      a = 32'h0000_6000;
      b = 32'h0000_2000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check32("abort_in_ready", 32'(in_ready), 32'd1);
      check32("abort_out_valid", 32'(out_valid), 32'd0);
      check32("abort_out", out, 32'd0);
      check32("abort_overflow", 32'(overflow), 32'd0);
      check32("abort_div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      do_op(32'hFFFF_8800, 32'h0000_2000, r_out, r_ovf, r_dbz, lat);
      $display("[TB] after_abort a=ffff8800 b=00002000 out=%h ovf=%0d dbz=%0d lat=%0d",
               r_out, r_ovf, r_dbz, lat);
      check32("after_abort_out", r_out, 32'hFFFF_C400);
      check32("after_abort_flags", {30'd0, r_ovf, r_dbz}, 32'd0);
      check_int("after_abort_latency", lat, LAT);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               ra = $urandom;
               rb = $urandom;
            end
            1: begin
               ra = $urandom;
               rb = 32'($urandom_range(1, 32'h0000_FFFF));
               if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            2: begin
               ra = 32'($signed($urandom_range(0, 32'h001F_FFFF)) - 32'sd1048576);
               rb = 32'($urandom_range(1, 32'h0000_FFFF));
               if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            default: begin
               ra = $urandom;
               rb = $urandom & 32'h0000_0007;
            end
         endcase
         model(ra, rb, e_out, e_ovf, e_dbz);
         do_op(ra, rb, r_out, r_ovf, r_dbz, lat);
         $display("[TB] random a=%h b=%h out=%h ovf=%0d dbz=%0d lat=%0d",
                  ra, rb, r_out, r_ovf, r_dbz, lat);
         check32("rand_out", r_out, e_out);
         check32("rand_ovf", 32'(r_ovf), 32'(e_ovf));
         check32("rand_dbz", 32'(r_dbz), 32'(e_dbz));
         check_int("rand_latency", lat, LAT);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
